// File: rtl/uart_tx_framer.sv
// uart_tx_framer: frames a parallel payload into a serial UART bit stream
// (start bit, DATA_WIDTH payload bits LSB first, optional parity, stop bit).
// One frame bit is produced per CLK cycle; TX_OUT is fully registered.
// Optional build macro UART_TX_TWO_STOP_EN adds a second stop bit (STOP2).
// Parity itself is computed outside this block: par_calc_en pulses in START
// with the latched payload/type on par_data/par_typ, and the result returns
// on par_bit in time for the PARITY bit.
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  par_bit,
  output logic                  par_calc_en,
  output logic [DATA_WIDTH-1:0] par_data,
  output logic                  par_typ,
  output logic                  TX_OUT,
  output logic                  busy
);

  // Counter is at least one bit wide so DATA_WIDTH=1 still elaborates.
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

`ifdef UART_TX_TWO_STOP_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    STOP2  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] bit_cnt_r;
  logic             par_en_r;

  // Frame sequencer: state, bit counter, latched request and every output
  // are registered here so TX_OUT changes only on the clock edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      bit_cnt_r   <= CNT_ZERO;
      par_en_r    <= 1'b0;
      par_data    <= {DATA_WIDTH{1'b0}};
      par_typ     <= 1'b0;
      par_calc_en <= 1'b0;
      TX_OUT      <= 1'b1;
      busy        <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (Data_Valid) begin
            state_r     <= START;
            par_data    <= P_DATA;
            par_en_r    <= PAR_EN;
            par_typ     <= PAR_TYP;
            par_calc_en <= PAR_EN;
            TX_OUT      <= 1'b0;
            busy        <= 1'b1;
          end else begin
            par_calc_en <= 1'b0;
            TX_OUT      <= 1'b1;
            busy        <= 1'b0;
          end
        end
        START: begin
          state_r     <= DATA;
          bit_cnt_r   <= CNT_ZERO;
          par_calc_en <= 1'b0;
          TX_OUT      <= par_data[0];
        end
        DATA: begin
          if (bit_cnt_r == CNT_LAST) begin
            if (par_en_r) begin
              state_r <= PARITY;
              TX_OUT  <= par_bit;
            end else begin
              state_r <= STOP;
              TX_OUT  <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + CNT_ONE;
            TX_OUT    <= par_data[bit_cnt_r + CNT_ONE];
          end
        end
        PARITY: begin
          state_r <= STOP;
          TX_OUT  <= 1'b1;
        end
`ifdef UART_TX_TWO_STOP_EN
        STOP: begin
          state_r <= STOP2;
          TX_OUT  <= 1'b1;
        end
        STOP2: begin
          state_r <= IDLE;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
        end
`else
        STOP: begin
          state_r <= IDLE;
          TX_OUT  <= 1'b1;
          busy    <= 1'b0;
        end
`endif
        default: begin
          state_r     <= IDLE;
          par_calc_en <= 1'b0;
          TX_OUT      <= 1'b1;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed self-checking bench for uart_tx_framer (DATA_WIDTH=8).
// Expected frame bit sequences are written MSB-first as the order they
// appear on TX_OUT (start bit first). The downstream parity calculator is
// modelled as a register loaded when par_calc_en is high.
module tb_uart_tx_framer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       par_bit;
  logic       par_calc_en;
  logic [7:0] par_data;
  logic       par_typ;
  logic       TX_OUT;
  logic       busy;

  int total = 0;
  int bad   = 0;

`ifdef UART_TX_TWO_STOP_EN
  localparam int EXTRA_STOP = 1;
`else
  localparam int EXTRA_STOP = 0;
`endif

  uart_tx_framer #(.DATA_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .par_bit(par_bit),
    .par_calc_en(par_calc_en), .par_data(par_data), .par_typ(par_typ),
    .TX_OUT(TX_OUT), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Parity calculator model: even parity of payload, inverted for odd.
  always @(posedge CLK or negedge RST) begin
    if (!RST) par_bit <= 1'b0;
    else if (par_calc_en) par_bit <= (^par_data) ^ par_typ;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // Walks one frame: n bits (plus an extra stop bit in the two-stop build),
  // then checks the idle cycle that follows. Inputs for the accept edge
  // must already be driven by the caller.
  task automatic expect_frame(input string tag, input int n, input logic [11:0] seq,
                              input logic pen, input logic ptyp, input logic [7:0] exp_d,
                              input logic [7:0] next_d, input bit drop_dv);
    int nn;
    logic [12:0] s;
    nn = n + EXTRA_STOP;
    s = (EXTRA_STOP == 1) ? {seq, 1'b1} : {1'b0, seq};
    for (int i = 0; i < nn; i++) begin
      @(posedge CLK); #1;
      chk($sformatf("%s tx[%0d]", tag, i), {31'd0, TX_OUT}, {31'd0, s[nn-1-i]});
      chk($sformatf("%s busy[%0d]", tag, i), {31'd0, busy}, 32'd1);
      chk($sformatf("%s pce[%0d]", tag, i), {31'd0, par_calc_en}, {31'd0, (i == 0) && pen});
      if (i == 0) begin
        P_DATA = next_d;
        if (drop_dv) Data_Valid = 1'b0;
      end
      if (i == 2) begin
        chk($sformatf("%s par_data", tag), {24'd0, par_data}, {24'd0, exp_d});
        chk($sformatf("%s par_typ", tag), {31'd0, par_typ}, {31'd0, ptyp});
      end
    end
    @(posedge CLK); #1;
    chk($sformatf("%s idle tx", tag), {31'd0, TX_OUT}, 32'd1);
    chk($sformatf("%s idle busy", tag), {31'd0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state while RST held low.
    #12;
    chk("rst tx", {31'd0, TX_OUT}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst par_data", {24'd0, par_data}, 32'd0);
    chk("rst pce", {31'd0, par_calc_en}, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("post-rst idle tx", {31'd0, TX_OUT}, 32'd1);

    // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    expect_frame("a5_even", 11, 12'b01010010101, 1'b1, 1'b0, 8'hA5, 8'h00, 1'b1);

    // 0xA5 odd parity: parity bit 1; inputs changed mid-frame must not matter.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b1; Data_Valid = 1'b1;
    expect_frame("a5_odd", 11, 12'b01010010111, 1'b1, 1'b1, 8'hA5, 8'h5A, 1'b1);

    // 0x01 without parity: 10-cycle frame, no par_calc_en.
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    expect_frame("01_nopar", 10, 12'b0100000001, 1'b0, 1'b0, 8'h01, 8'h00, 1'b1);

    // Data_Valid held high: 0x3C then 0xC3 with one idle bit between.
    P_DATA = 8'h3C; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    expect_frame("hold_3c", 10, 12'b0001111001, 1'b0, 1'b0, 8'h3C, 8'hC3, 1'b0);
    expect_frame("hold_c3", 10, 12'b0110000111, 1'b0, 1'b0, 8'hC3, 8'hC3, 1'b1);

    // Reset pulsed during 4th DATA bit of 0xA5 with parity.
    P_DATA = 8'hA5; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    @(posedge CLK); #1;
    Data_Valid = 1'b0;
    chk("mid start tx", {31'd0, TX_OUT}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
    end
    chk("mid bit3 tx", {31'd0, TX_OUT}, 32'd0);
    chk("mid bit3 busy", {31'd0, busy}, 32'd1);
    #2 RST = 1'b0;
    #1;
    chk("mid rst tx", {31'd0, TX_OUT}, 32'd1);
    chk("mid rst busy", {31'd0, busy}, 32'd0);
    chk("mid rst par_data", {24'd0, par_data}, 32'd0);
    chk("mid rst par_typ", {31'd0, par_typ}, 32'd0);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("after rst idle tx", {31'd0, TX_OUT}, 32'd1);
    chk("after rst idle busy", {31'd0, busy}, 32'd0);

    // Complete frame after reset: 0x3C even parity 0.
    P_DATA = 8'h3C; PAR_EN = 1'b1; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    expect_frame("post_rst_3c", 11, 12'b00011110001, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1);

    // 0xFF without parity: stop-bit count follows the build configuration.
    P_DATA = 8'hFF; PAR_EN = 1'b0; PAR_TYP = 1'b0; Data_Valid = 1'b1;
    expect_frame("ff_nopar", 10, 12'b0111111111, 1'b0, 1'b0, 8'hFF, 8'h00, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, giving the payload bits per frame.
REQ-002 SHALL have CLK  input  1  transmit bit clock; one frame bit per CLK cycle.
REQ-003 SHALL have RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have P_DATA  input  DATA_WIDTH  parallel payload to send.
REQ-005 SHALL have Data_Valid  input  1  request to send P_DATA; sampled on CLK rising edge.
REQ-006 SHALL have PAR_EN  input  1  1 = parity bit inserted after the payload.
REQ-007 SHALL have PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-008 SHALL have par_bit  input  1  parity result from the downstream parity calculator.
REQ-009 SHALL have par_calc_en  output  1  enable pulse to the parity calculator.
REQ-010 SHALL have par_data  output  DATA_WIDTH  latched payload fed to the parity calculator.
REQ-011 SHALL have par_typ  output  1  latched PAR_TYP fed to the parity calculator.
REQ-012 SHALL have TX_OUT  output  1  serial line; idle high.
REQ-013 SHALL have busy  output  1  1 while a frame is in progress.

Function
REQ-014 SHALL implement a registered FSM with states IDLE, START, DATA, PARITY, STOP (plus STOP2 per REQ-029).
REQ-015 SHALL accept a request only in IDLE with Data_Valid=1; on that edge it latches P_DATA into par_data, PAR_EN, and PAR_TYP into par_typ, and moves to START.
REQ-016 SHALL ignore Data_Valid in every non-IDLE state; the latched data and configuration stay stable until the frame ends.
REQ-017 SHALL drive TX_OUT=1 in IDLE and STOP, and TX_OUT=0 in START, each for exactly one cycle per bit.
REQ-018 SHALL spend exactly DATA_WIDTH cycles in DATA, driving par_data LSB first, with a bit counter of width clog2(DATA_WIDTH).
REQ-019 SHALL go from DATA to PARITY when latched PAR_EN=1, and otherwise go straight to STOP.
REQ-020 SHALL drive TX_OUT=par_bit for one cycle in PARITY.
REQ-021 SHALL assert par_calc_en for exactly one cycle, during START, and only when latched PAR_EN=1; par_bit is therefore valid from the first DATA cycle onward.
REQ-022 SHALL return from STOP to IDLE, so at least one idle bit separates consecutive frames.
REQ-023 SHALL register TX_OUT, with no combinational path from inputs to TX_OUT.
REQ-024 SHALL assert busy in every state except IDLE; busy rises on the edge that accepts a request.
REQ-025 SHALL give a frame length of 1 + DATA_WIDTH + PAR_EN + stop bits, in cycles.
REQ-026 SHALL leave the counter saturation-free: it is cleared on entering DATA, and DATA exits when the counter equals DATA_WIDTH-1.

Reset
REQ-027 SHALL, when RST=0 at any time (including mid-frame), immediately force: state IDLE, TX_OUT=1, busy=0, par_calc_en=0, par_data=0, par_typ=0, bit counter=0, latched PAR_EN=0.
REQ-028 SHALL, after RST deasserts, accept a request no earlier than the first CLK edge with RST=1.

Configuration
REQ-029 SHALL, with macro UART_TX_TWO_STOP_EN defined, add state STOP2 after STOP, driving TX_OUT=1 for a second stop cycle before IDLE; without the macro, STOP goes directly to IDLE and STOP2 does not exist.

Verification
REQ-030 SHALL cover: DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0(parity),1; busy high for 11 cycles.
REQ-031 SHALL cover: P_DATA=0xA5, PAR_EN=1, PAR_TYP=1 -> parity cycle TX_OUT=1; par_calc_en high only in the START cycle; par_typ=1.
REQ-032 SHALL cover: P_DATA=0x01, PAR_EN=0 -> TX_OUT 0,1,0,0,0,0,0,0,0,1; 10-cycle frame; par_calc_en never asserted.
REQ-033 SHALL cover: Data_Valid held high continuously with 0x3C then 0xC3 -> the second frame starts only after one IDLE cycle (TX_OUT=1, busy=0), and the first payload is uncorrupted.
REQ-034 SHALL cover: RST pulsed low during the 4th DATA bit -> TX_OUT=1 and busy=0 immediately; the next request produces a complete, correct frame.
REQ-035 SHALL cover: with UART_TX_TWO_STOP_EN defined, 0xFF, PAR_EN=0 -> 11-cycle frame ending in two TX_OUT=1 stop cycles.
